wb_arbiter_v: RTL and testbench

- Shares the single vector register-file write port between the four write-back streams of the vector execution unit: LdSt1, LdSt2, Math and Mv.
- Each stream is buffered in a small per-source FIFO; a round-robin arbiter drains the FIFOs into one registered write port using a valid/ready handshake.
- Raises a stall request toward issue before any FIFO can overflow. Sits between the vector exec unit and the vector register file.

---
 rtl/wb_arbiter_v_pkg.sv | 21 ++
 rtl/wb_arbiter_v_if.sv | 33 +++
 rtl/wb_arbiter_v_fifo.sv | 57 +++++
 rtl/wb_arbiter_v.sv | 140 ++++++++++++++
 tb/tb_wb_arbiter_v.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_v_pkg.sv
// wb_arbiter_v_pkg: shared constants and types for the vector write-back arbiter.
//   WB_NUM_SRC      number of write-back streams
//   WB_SRC_*        source ids (bit positions in the per-source vectors)
//   wb_src_t        2-bit source id
//   wb_onehot()     source id -> one-hot source vector
package wb_arbiter_v_pkg;
  localparam int WB_NUM_SRC   = 4;
  localparam int WB_SRC_LDST1 = 0;
  localparam int WB_SRC_LDST2 = 1;
  localparam int WB_SRC_MATH  = 2;
  localparam int WB_SRC_MV    = 3;

  typedef logic [1:0] wb_src_t;

  function automatic logic [WB_NUM_SRC-1:0] wb_onehot(wb_src_t s);
    logic [WB_NUM_SRC-1:0] r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/wb_arbiter_v_if.sv
// wb_arbiter_v_if: bundle of write-back inputs and register-file write outputs.
//   I_Flush, I_Valid, I_Token, I_Data, I_RF_Ready : exec unit / RF -> arbiter
//   O_We, O_Src, O_Token, O_Data, O_Done,
//   O_Stall, O_Overflow                           : arbiter -> RF / issue
// modport slave is the arbiter side, master is the environment side.
interface wb_arbiter_v_if
  import wb_arbiter_v_pkg::*;
#(
  parameter int TOKEN_W = 32,
  parameter int DATA_W  = 32
);
  logic                                 I_Flush;
  logic [WB_NUM_SRC-1:0]                I_Valid;
  logic [WB_NUM_SRC-1:0][TOKEN_W-1:0]   I_Token;
  logic [WB_NUM_SRC-1:0][DATA_W-1:0]    I_Data;
  logic                                 I_RF_Ready;
  logic                                 O_We;
  wb_src_t                              O_Src;
  logic [TOKEN_W-1:0]                   O_Token;
  logic [DATA_W-1:0]                    O_Data;
  logic [WB_NUM_SRC-1:0]                O_Done;
  logic                                 O_Stall;
  logic                                 O_Overflow;

  modport slave (
    input  I_Flush, I_Valid, I_Token, I_Data, I_RF_Ready,
    output O_We, O_Src, O_Token, O_Data, O_Done, O_Stall, O_Overflow
  );
  modport master (
    output I_Flush, I_Valid, I_Token, I_Data, I_RF_Ready,
    input  O_We, O_Src, O_Token, O_Data, O_Done, O_Stall, O_Overflow
  );
endinterface

// File: rtl/wb_arbiter_v_fifo.sv
// wb_fifo: per-source write-back FIFO.
//   clk, rst_n (async, active low), flush_i (sync clear)
//   push_i/din_i : enqueue; a push to a full FIFO is dropped unless pop_i
//                  is also set in the same cycle (count then unchanged)
//   pop_i        : dequeue head_o
//   count_o, full_o, empty_o : occupancy
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   rd_q, wr_q;
  logic [AW:0]     cnt_q;
  logic            push_ok, pop_ok;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  // When full, the slot being popped is the one written, so push+pop is safe.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/wb_arbiter_v.sv
// wb_arbiter_v: round-robin arbiter sharing the vector RF write port between
// the LdSt1, LdSt2, Math and Mv write-back streams.
//   clock, reset (async, active low)
//   bus (wb_arbiter_v_if.slave): per-source valid/token/data in, flush,
//     RF ready; registered write port (We/Src/Token/Data), Done pulses,
//     Stall request to issue, sticky Overflow.
// Build option WB_ARBITER_BYPASS_EN: a source with an empty FIFO and a valid
// input competes directly and may load the output register without queueing.
module wb_arbiter_v
  import wb_arbiter_v_pkg::*;
#(
  parameter int TOKEN_W      = 32,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4,
  parameter int STALL_MARGIN = 2
) (
  input logic           clock,
  input logic           reset,
  wb_arbiter_v_if.slave bus
);
  localparam int EW = TOKEN_W + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - STALL_MARGIN);

  logic [WB_NUM_SRC-1:0]         push, pop, full, empty, byp, cand;
  logic [WB_NUM_SRC-1:0][EW-1:0] head;
  logic [WB_NUM_SRC-1:0][CW-1:0] cnt;

  logic                  we_q, we_d;
  wb_src_t               src_q, src_d, ptr_q, ptr_d;
  logic [TOKEN_W-1:0]    tok_q, tok_d;
  logic [DATA_W-1:0]     dat_q, dat_d;
  logic [WB_NUM_SRC-1:0] done_q, done_d;
  logic                  stall_q, stall_d, ovf_q, ovf_d;

  logic                  or_free, win_vld;
  wb_src_t               win, idx;
  logic [EW-1:0]         win_ent;
  logic [CW-1:0]         nxt;

  for (genvar i = 0; i < WB_NUM_SRC; i++) begin : g_fifo
    wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk     (clock),
      .rst_n   (reset),
      .flush_i (bus.I_Flush),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .din_i   ({bus.I_Token[i], bus.I_Data[i]}),
      .head_o  (head[i]),
      .count_o (cnt[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  // Round-robin pick: scan from the far end back to ptr so the candidate
  // nearest ptr is the last one written.
  always_comb begin
    or_free = ~we_q | bus.I_RF_Ready;
`ifdef WB_ARBITER_BYPASS_EN
    cand = ~empty | bus.I_Valid;
`else
    cand = ~empty;
`endif
    win_vld = 1'b0;
    win     = ptr_q;
    idx     = ptr_q;
    for (int k = WB_NUM_SRC - 1; k >= 0; k--) begin
      idx = ptr_q + wb_src_t'(k);
      if (cand[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
    pop = '0;
    byp = '0;
`ifdef WB_ARBITER_BYPASS_EN
    // Queued entries shadow the live input of the same source.
    if (or_free && win_vld) begin
      if (empty[win]) byp = wb_onehot(win);
      else            pop = wb_onehot(win);
    end
    win_ent = empty[win] ? {bus.I_Token[win], bus.I_Data[win]} : head[win];
`else
    if (or_free && win_vld) pop = wb_onehot(win);
    win_ent = head[win];
`endif
    push = bus.I_Valid & ~byp;
  end

  always_comb begin
    we_d  = we_q;
    src_d = src_q;
    tok_d = tok_q;
    dat_d = dat_q;
    ptr_d = ptr_q;
    if (or_free) begin
      we_d = win_vld;
      if (win_vld) begin
        src_d          = win;
        {tok_d, dat_d} = win_ent;
        ptr_d          = wb_src_t'(win + 2'd1);
      end
    end
    done_d = (we_q && bus.I_RF_Ready) ? wb_onehot(src_q) : '0;
  end

  // Stall looks at next-state occupancy so issue sees it one cycle earlier.
  always_comb begin
    stall_d = 1'b0;
    ovf_d   = ovf_q;
    nxt     = '0;
    for (int i = 0; i < WB_NUM_SRC; i++) begin
      nxt = cnt[i] + CW'(push[i] & (~full[i] | pop[i])) - CW'(pop[i]);
      if (nxt >= STALL_LVL)              stall_d = 1'b1;
      if (push[i] & full[i] & ~pop[i])   ovf_d   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_q <= 1'b0; src_q <= '0; tok_q <= '0; dat_q <= '0; ptr_q <= '0;
      done_q <= '0; stall_q <= 1'b0; ovf_q <= 1'b0;
    end else if (bus.I_Flush) begin
      we_q <= 1'b0; src_q <= '0; tok_q <= '0; dat_q <= '0; ptr_q <= '0;
      done_q <= '0; stall_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      we_q <= we_d; src_q <= src_d; tok_q <= tok_d; dat_q <= dat_d; ptr_q <= ptr_d;
      done_q <= done_d; stall_q <= stall_d; ovf_q <= ovf_d;
    end
  end

  assign bus.O_We       = we_q;
  assign bus.O_Src      = src_q;
  assign bus.O_Token    = tok_q;
  assign bus.O_Data     = dat_q;
  assign bus.O_Done     = done_q;
  assign bus.O_Stall    = stall_q;
  assign bus.O_Overflow = ovf_q;
endmodule

// File: tb/tb_wb_arbiter_v.sv
// tb_wb_arbiter_v: directed bench for wb_arbiter_v. A queue-level model of the
// arbiter is stepped on every clock edge and compared against all outputs each
// cycle; directed scenarios add hand-computed expectations on top.
module tb_wb_arbiter_v;
  import wb_arbiter_v_pkg::*;
  localparam int DEPTH  = 4;
  localparam int MARGIN = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  wb_arbiter_v_if #(.TOKEN_W(32), .DATA_W(32)) bus ();

  wb_arbiter_v #(.TOKEN_W(32), .DATA_W(32), .DEPTH(DEPTH), .STALL_MARGIN(MARGIN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // model state: per-source queues of {token,data}, output register, pointer
  logic [63:0] mb [4][DEPTH];
  int          mn [4];
  logic        m_we, m_stall, m_ovf;
  logic [1:0]  m_src;
  logic [63:0] m_ent;
  logic [3:0]  m_done;
  int          m_ptr;

  // writes accepted by the RF, as seen on the DUT outputs
  logic [1:0]  log_src [64];
  logic [31:0] log_dat [64];
  int          nlog = 0;
  int          n0;
  logic [1:0]  exp3 [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mn[i] = 0;
    m_we = 1'b0; m_src = '0; m_ent = '0; m_done = '0;
    m_stall = 1'b0; m_ovf = 1'b0; m_ptr = 0;
  endtask

  task automatic model_step();
    logic [3:0] nd, byp;
    int win, s;
    bit found, avail;
    if (bus.I_Flush) begin
      model_clear();
      return;
    end
    nd  = (m_we && bus.I_RF_Ready) ? (4'b0001 << m_src) : 4'b0000;
    byp = '0;
    if (!m_we || bus.I_RF_Ready) begin
      found = 0;
      win   = 0;
      for (int k = 0; k < 4; k++) begin
        s     = (m_ptr + k) % 4;
        avail = mn[s] > 0;
`ifdef WB_ARBITER_BYPASS_EN
        avail = avail || bus.I_Valid[s];
`endif
        if (!found && avail) begin found = 1; win = s; end
      end
      if (found) begin
        m_we  = 1'b1;
        m_src = 2'(win);
        m_ptr = (win + 1) % 4;
        if (mn[win] > 0) begin
          m_ent = mb[win][0];
          for (int j = 0; j < DEPTH - 1; j++) mb[win][j] = mb[win][j+1];
          mn[win]--;
        end else begin
          m_ent    = {bus.I_Token[win], bus.I_Data[win]};
          byp[win] = 1'b1;
        end
      end else begin
        m_we = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.I_Valid[i] && !byp[i]) begin
        if (mn[i] >= DEPTH) m_ovf = 1'b1;
        else begin
          mb[i][mn[i]] = {bus.I_Token[i], bus.I_Data[i]};
          mn[i]++;
        end
      end
    end
    m_stall = 1'b0;
    for (int i = 0; i < 4; i++) if (mn[i] >= DEPTH - MARGIN) m_stall = 1'b1;
    m_done = nd;
  endtask

  task automatic compare_all();
    chk("we", 64'(bus.O_We), 64'(m_we));
    if (m_we) begin
      chk("src",   64'(bus.O_Src),   64'(m_src));
      chk("token", 64'(bus.O_Token), 64'(m_ent[63:32]));
      chk("data",  64'(bus.O_Data),  64'(m_ent[31:0]));
    end
    chk("done",  64'(bus.O_Done),     64'(m_done));
    chk("stall", 64'(bus.O_Stall),    64'(m_stall));
    chk("ovf",   64'(bus.O_Overflow), 64'(m_ovf));
  endtask

  // Called at the negedge once inputs for the coming edge are set.
  task automatic cyc();
    if (reset && !bus.I_Flush && bus.O_We && bus.I_RF_Ready && nlog < 64) begin
      log_src[nlog] = bus.O_Src;
      log_dat[nlog] = bus.O_Data;
      nlog++;
    end
    @(posedge clock);
    if (reset) model_step();
    else       model_clear();
    @(negedge clock);
    compare_all();
  endtask

  task automatic set_push(input int s, input logic [31:0] tok, input logic [31:0] dat);
    bus.I_Valid[s] = 1'b1;
    bus.I_Token[s] = tok;
    bus.I_Data[s]  = dat;
  endtask

  task automatic clr_push();
    bus.I_Valid = '0;
  endtask

  task automatic do_flush();
    bus.I_Flush = 1'b1;
    cyc();
    bus.I_Flush = 1'b0;
  endtask

  task automatic push_all(input logic [31:0] base);
    for (int s = 0; s < 4; s++) set_push(s, 32'h100 + 32'(s), base + 32'(s));
  endtask

  initial begin
    bus.I_Flush = 1'b0; bus.I_Valid = '0; bus.I_Token = '0; bus.I_Data = '0;
    bus.I_RF_Ready = 1'b1;
    exp3 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    model_clear();

    // reset state
    repeat (2) cyc();
    chk("rst_we",    64'(bus.O_We),       64'd0);
    chk("rst_done",  64'(bus.O_Done),     64'd0);
    chk("rst_stall", 64'(bus.O_Stall),    64'd0);
    chk("rst_ovf",   64'(bus.O_Overflow), 64'd0);
    reset = 1'b1;

    // single Math push: latency and Done pulse
    set_push(WB_SRC_MATH, 32'h0200_0001, 32'h3F80_0000);
    cyc();
    clr_push();
`ifdef WB_ARBITER_BYPASS_EN
    chk("t1_we_c2",   64'(bus.O_We),   64'd1);
    chk("t1_data_c2", 64'(bus.O_Data), 64'h3F80_0000);
    cyc();
    chk("t1_done", 64'(bus.O_Done), 64'b0100);
`else
    chk("t1_we_c2", 64'(bus.O_We), 64'd0);
    cyc();
    chk("t1_we_c3",   64'(bus.O_We),   64'd1);
    chk("t1_src_c3",  64'(bus.O_Src),  64'd2);
    chk("t1_data_c3", 64'(bus.O_Data), 64'h3F80_0000);
    cyc();
    chk("t1_done", 64'(bus.O_Done), 64'b0100);
`endif
    repeat (3) cyc();

    // all four push with ptr=0 -> 0,1,2,3
    do_flush();
    n0 = nlog;
    push_all(32'hA000);
    cyc();
    clr_push();
    repeat (7) cyc();
    chk("t2_cnt", 64'(nlog - n0), 64'd4);
    for (int i = 0; i < 4; i++) chk("t2_order", 64'(log_src[n0+i]), 64'(i));

    // ptr moved to 2 by a lone LdSt2 write -> 1, then 2,3,0,1
    do_flush();
    n0 = nlog;
    set_push(WB_SRC_LDST2, 32'h111, 32'hB001);
    cyc();
    clr_push();
    repeat (4) cyc();
    push_all(32'hB100);
    cyc();
    clr_push();
    repeat (7) cyc();
    chk("t3_cnt", 64'(nlog - n0), 64'd5);
    for (int i = 0; i < 5; i++) chk("t3_order", 64'(log_src[n0+i]), 64'(exp3[i]));

    // RF not ready: output held, no Done, one write on release
    bus.I_RF_Ready = 1'b0;
    do_flush();
    n0 = nlog;
    set_push(WB_SRC_MV, 32'h333, 32'h0000_00AA);
    cyc();
    clr_push();
    cyc();
    repeat (5) begin
      cyc();
      chk("t4_hold_we",   64'(bus.O_We),   64'd1);
      chk("t4_hold_data", 64'(bus.O_Data), 64'hAA);
      chk("t4_no_done",   64'(bus.O_Done), 64'd0);
    end
    bus.I_RF_Ready = 1'b1;
    repeat (4) cyc();
    chk("t4_one_write", 64'(nlog - n0), 64'd1);
    chk("t4_wr_data",   64'(log_dat[n0]), 64'hAA);

    // Math fills its FIFO: stall, overflow, 6th entry dropped
    bus.I_RF_Ready = 1'b0;
    do_flush();
    n0 = nlog;
    for (int d = 1; d <= 6; d++) begin
      set_push(WB_SRC_MATH, 32'h0200_0000 + 32'(d), 32'(d));
      cyc();
      if (d == 5) chk("t5_ovf_pre", 64'(bus.O_Overflow), 64'd0);
    end
    clr_push();
    chk("t5_ovf",   64'(bus.O_Overflow), 64'd1);
    chk("t5_stall", 64'(bus.O_Stall),    64'd1);
    chk("t5_head",  64'(bus.O_Data),     64'd1);
    bus.I_RF_Ready = 1'b1;
    repeat (8) cyc();
    chk("t5_cnt", 64'(nlog - n0), 64'd5);
    for (int i = 0; i < 5; i++) chk("t5_seq", 64'(log_dat[n0+i]), 64'(i + 1));
    chk("t5_ovf_sticky", 64'(bus.O_Overflow), 64'd1);

    // asynchronous reset mid-stream
    push_all(32'hC001);
    cyc();
    clr_push();
    cyc();
    #2 reset = 1'b0;
    #1;
    chk("t6_we",   64'(bus.O_We),       64'd0);
    chk("t6_src",  64'(bus.O_Src),      64'd0);
    chk("t6_data", 64'(bus.O_Data),     64'd0);
    chk("t6_done", 64'(bus.O_Done),     64'd0);
    chk("t6_ovf",  64'(bus.O_Overflow), 64'd0);
    model_clear();
    cyc();
    reset = 1'b1;
    n0 = nlog;
    repeat (4) cyc();
    chk("t6_no_wr", 64'(nlog - n0), 64'd0);

    // flush with entries pending
    bus.I_RF_Ready = 1'b0;
    for (int s = 0; s < 3; s++) set_push(s, 32'h700 + 32'(s), 32'hD000 + 32'(s));
    cyc();
    cyc();
    clr_push();
    chk("t7_stall_pre", 64'(bus.O_Stall), 64'd1);
    do_flush();
    chk("t7_we",    64'(bus.O_We),    64'd0);
    chk("t7_stall", 64'(bus.O_Stall), 64'd0);
    bus.I_RF_Ready = 1'b1;
    n0 = nlog;
    repeat (5) cyc();
    chk("t7_no_wr", 64'(nlog - n0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
